// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer.
package mips_ctrl_pkg;

    // Sequencer states; codes 12-15 are unused and recover to StFetch.
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StRWb      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StAddiEx   = 4'd10,
        StAddiWb   = 4'd11
    } state_e;

    // Opcodes from instr[31:26].
    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpJ    = 6'b000010;
    localparam logic [5:0] OpAddi = 6'b001000;

    typedef enum logic [1:0] {
        AluAdd   = 2'b00,
        AluSub   = 2'b01,
        AluFunct = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        SrcBRt    = 2'b00,
        SrcBFour  = 2'b01,
        SrcBImm   = 2'b10,
        SrcBImmSh = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PcAlu    = 2'b00,
        PcAluOut = 2'b01,
        PcJump   = 2'b10
    } pc_source_e;

    // All datapath controls produced from the current state.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_en;
        pc_source_e pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OpR) || (op == OpLw) || (op == OpSw) ||
               (op == OpBeq) || (op == OpJ) || (op == OpAddi);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the sequencer (master) and the datapath (slave).
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, pc_en, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               illegal, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, pc_en, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               illegal, state
    );
endinterface

// File: rtl/multicycle_control_output_decode.sv
// Moore output decode: maps the sequencer state to datapath controls.
module ctrl_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_e state,
    input  logic   zero,
    output ctrl_t  ctrl
);

    // Per-state control table; FETCH strobes assume the mem_ready cycle and are
    // qualified by the top level.
    always_comb begin
        ctrl = '0;
        unique case (state)
            StFetch: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SrcBFour;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
            end
            StDecode: begin
                ctrl.alu_src_b = SrcBImmSh;
            end
            StMemAddr: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
            end
            StMemRead: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            StMemWb: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            StMemWrite: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            StExecute: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = AluFunct;
            end
            StRWb: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            StBranch: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = AluSub;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PcAluOut;
            end
            StJump: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PcJump;
            end
            StAddiEx: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SrcBImm;
            end
            StAddiWb: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
        // zero only matters where pc_write_cond is set, i.e. BRANCH.
        ctrl.pc_en = ctrl.pc_write | (ctrl.pc_write_cond & zero);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXECUTE/MEM/WB over 3-5 cycles.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input logic               clk,
    input logic               reset,
    multicycle_control_if.master bus
);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    ctrl_t      dec_ctrl;
    ctrl_t      out_ctrl;
    logic       illegal_raw;

    // State and latched opcode register, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic; opcode is captured in DECODE and op_q used afterwards.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            StFetch: begin
                if (bus.mem_ready) state_d = StDecode;
            end
            StDecode: begin
                op_d = bus.opcode;
                case (bus.opcode)
                    OpLw, OpSw: state_d = StMemAddr;
                    OpR:        state_d = StExecute;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiEx;
                    default:    state_d = StFetch;
                endcase
            end
            StMemAddr: begin
                if (op_q == OpLw)      state_d = StMemRead;
                else if (op_q == OpSw) state_d = StMemWrite;
                else                   state_d = StFetch;
            end
            StMemRead: begin
                if (bus.mem_ready) state_d = StMemWb;
            end
            StMemWb:    state_d = StFetch;
            StMemWrite: begin
                if (bus.mem_ready) state_d = StFetch;
            end
            StExecute:  state_d = StRWb;
            StRWb:      state_d = StFetch;
            StBranch:   state_d = StFetch;
            StJump:     state_d = StFetch;
            StAddiEx:   state_d = StAddiWb;
            StAddiWb:   state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    ctrl_output_decode u_output_decode (
        .state (state_q),
        .zero  (bus.zero),
        .ctrl  (dec_ctrl)
    );

    // Output stage: hold fetch write strobes until memory completes, force 0 in reset.
    always_comb begin
        out_ctrl    = dec_ctrl;
        illegal_raw = (state_q == StDecode) && !is_supported(bus.opcode);
        if ((state_q == StFetch) && !bus.mem_ready) begin
            out_ctrl.ir_write = 1'b0;
            out_ctrl.pc_write = 1'b0;
            out_ctrl.pc_en    = 1'b0;
        end
        if (reset) begin
            out_ctrl    = '0;
            illegal_raw = 1'b0;
        end
    end

    assign bus.pc_write      = out_ctrl.pc_write;
    assign bus.pc_write_cond = out_ctrl.pc_write_cond;
    assign bus.pc_en         = out_ctrl.pc_en;
    assign bus.pc_source     = out_ctrl.pc_source;
    assign bus.i_or_d        = out_ctrl.i_or_d;
    assign bus.mem_read      = out_ctrl.mem_read;
    assign bus.mem_write     = out_ctrl.mem_write;
    assign bus.ir_write      = out_ctrl.ir_write;
    assign bus.reg_dst       = out_ctrl.reg_dst;
    assign bus.mem_to_reg    = out_ctrl.mem_to_reg;
    assign bus.reg_write     = out_ctrl.reg_write;
    assign bus.alu_src_a     = out_ctrl.alu_src_a;
    assign bus.alu_src_b     = out_ctrl.alu_src_b;
    assign bus.alu_op        = out_ctrl.alu_op;
    assign bus.illegal       = illegal_raw;
    assign bus.state         = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    wire [21:0] all_outs = {bus.pc_write, bus.pc_write_cond, bus.pc_en, bus.pc_source,
                            bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                            bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                            bus.alu_src_b, bus.alu_op, bus.illegal, bus.state};

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.zero = 1'b1;
        bus.opcode = OP_BAD;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (all_outs !== 22'd0) $display("FAIL reset_outs[%0d]: got %h expected 0", i, all_outs);
            else n_pass++;
            tick();
        end
        reset = 1'b0;
        bus.zero = 1'b0;
        #1;
        n_total++;
        if ({bus.state, bus.mem_read, bus.pc_write, bus.ir_write, bus.pc_en} !== 8'b0000_1111)
            $display("FAIL reset_release: got st=%0d mr=%b pw=%b iw=%b pe=%b expected 0 1 1 1 1",
                     bus.state, bus.mem_read, bus.pc_write, bus.ir_write, bus.pc_en);
        else n_pass++;
    endtask

    // FETCH stalls two cycles, then a jump.
    task automatic test_fetch_stall_jump();
        int st[6]  = '{0, 0, 0, 1, 9, 0};
        bit rdy[6] = '{0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 6; i++) begin
            bus.mem_ready = rdy[i];
            bus.opcode = (i == 3) ? OP_J : OP_BAD;
            #1;
            n_total++;
            if (bus.state !== 4'(st[i]))
                $display("FAIL stall_j_state[%0d]: got %0d expected %0d", i, bus.state, st[i]);
            else n_pass++;
            if (st[i] == 0) begin
                n_total++;
                if ({bus.mem_read, bus.ir_write, bus.pc_write} !== {1'b1, rdy[i], rdy[i]})
                    $display("FAIL fetch_strobes[%0d]: got mr/iw/pw=%b%b%b expected 1%b%b", i,
                             bus.mem_read, bus.ir_write, bus.pc_write, rdy[i], rdy[i]);
                else n_pass++;
            end
            if (st[i] == 9) begin
                n_total++;
                if ({bus.pc_en, bus.pc_write, bus.pc_source} !== 4'b1110)
                    $display("FAIL jump_pc: got pe/pw/src=%b%b%b expected 1110",
                             bus.pc_en, bus.pc_write, bus.pc_source);
                else n_pass++;
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_lw();
        int st[8]  = '{0, 1, 2, 3, 3, 3, 4, 0};
        bit rdy[8] = '{1, 1, 1, 0, 0, 1, 1, 1};
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = rdy[i];
            // After DECODE the live opcode is changed to catch use of it over op_q.
            bus.opcode = (i <= 1) ? OP_LW : OP_SW;
            #1;
            n_total++;
            if (bus.state !== 4'(st[i]))
                $display("FAIL lw_state[%0d]: got %0d expected %0d", i, bus.state, st[i]);
            else n_pass++;
            n_total++;
            if ({bus.reg_write, bus.mem_to_reg} !== {2{st[i] == 4}})
                $display("FAIL lw_wb[%0d]: got rw/mtr=%b%b expected %b%b", i, bus.reg_write,
                         bus.mem_to_reg, st[i] == 4, st[i] == 4);
            else n_pass++;
            if (st[i] == 3) begin
                n_total++;
                if ({bus.mem_read, bus.i_or_d, bus.mem_write} !== 3'b110)
                    $display("FAIL lw_memread[%0d]: got mr/iod/mw=%b%b%b expected 110", i,
                             bus.mem_read, bus.i_or_d, bus.mem_write);
                else n_pass++;
            end
            if (i < 7) tick();
        end
    endtask

    task automatic test_beq();
        int st[7]  = '{0, 1, 8, 0, 1, 8, 0};
        bit zr[7]  = '{1, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            bus.mem_ready = 1'b1;
            bus.zero = zr[i];
            bus.opcode = OP_BEQ;
            #1;
            n_total++;
            if (bus.state !== 4'(st[i]))
                $display("FAIL beq_state[%0d]: got %0d expected %0d", i, bus.state, st[i]);
            else n_pass++;
            if (st[i] == 8) begin
                n_total++;
                if ({bus.pc_en, bus.pc_write_cond, bus.pc_source, bus.alu_op, bus.alu_src_a}
                    !== {zr[i], 6'b101011})
                    $display("FAIL beq_ctrl[%0d]: got pe/pwc/src/op/a=%b%b%b%b%b expected %b101011",
                             i, bus.pc_en, bus.pc_write_cond, bus.pc_source, bus.alu_op,
                             bus.alu_src_a, zr[i]);
                else n_pass++;
            end
            if (st[i] == 1) begin
                n_total++;
                if ({bus.pc_en, bus.alu_src_b} !== 3'b011)
                    $display("FAIL decode_ctrl[%0d]: got pe/srcb=%b%b expected 011", i,
                             bus.pc_en, bus.alu_src_b);
                else n_pass++;
            end
            if (i < 6) tick();
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_r_sw();
        int st[10] = '{0, 1, 6, 7, 0, 1, 2, 5, 5, 0};
        bit rdy[10] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
        for (int i = 0; i < 10; i++) begin
            bus.mem_ready = rdy[i];
            bus.opcode = (i < 4) ? OP_R : OP_SW;
            #1;
            n_total++;
            if (bus.state !== 4'(st[i]))
                $display("FAIL rsw_state[%0d]: got %0d expected %0d", i, bus.state, st[i]);
            else n_pass++;
            if (st[i] == 6) begin
                n_total++;
                if ({bus.alu_op, bus.alu_src_a, bus.reg_write} !== 4'b1010)
                    $display("FAIL r_exec: got op/a/rw=%b%b%b expected 1010",
                             bus.alu_op, bus.alu_src_a, bus.reg_write);
                else n_pass++;
            end
            if (st[i] == 7) begin
                n_total++;
                if ({bus.reg_dst, bus.reg_write, bus.mem_to_reg} !== 3'b110)
                    $display("FAIL r_wb: got rd/rw/mtr=%b%b%b expected 110",
                             bus.reg_dst, bus.reg_write, bus.mem_to_reg);
                else n_pass++;
            end
            if (st[i] == 5) begin
                n_total++;
                if ({bus.mem_write, bus.i_or_d, bus.mem_read} !== 3'b110)
                    $display("FAIL sw_memwrite[%0d]: got mw/iod/mr=%b%b%b expected 110", i,
                             bus.mem_write, bus.i_or_d, bus.mem_read);
                else n_pass++;
            end
            if (i >= 4) begin
                n_total++;
                if (bus.reg_write !== 1'b0)
                    $display("FAIL sw_no_regwrite[%0d]: got %b expected 0", i, bus.reg_write);
                else n_pass++;
            end
            if (i < 9) tick();
        end
    endtask

    task automatic test_addi();
        int st[5] = '{0, 1, 10, 11, 0};
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = 1'b1;
            bus.opcode = OP_ADDI;
            #1;
            n_total++;
            if ({bus.state, bus.reg_write} !== {4'(st[i]), st[i] == 11})
                $display("FAIL addi[%0d]: got st=%0d rw=%b expected %0d %b", i, bus.state,
                         bus.reg_write, st[i], st[i] == 11);
            else n_pass++;
            if (i < 4) tick();
        end
    endtask

    task automatic test_illegal();
        int st[3] = '{0, 1, 0};
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'b1;
            bus.opcode = OP_BAD;
            #1;
            n_total++;
            if ({bus.state, bus.illegal, bus.mem_write, bus.reg_write} !== {4'(st[i]), i == 1, 2'b00})
                $display("FAIL illegal[%0d]: got st=%0d ill=%b mw=%b rw=%b expected %0d %b 0 0", i,
                         bus.state, bus.illegal, bus.mem_write, bus.reg_write, st[i], i == 1);
            else n_pass++;
            if (i == 1) begin
                n_total++;
                if ({bus.ir_write, bus.pc_write} !== 2'b00)
                    $display("FAIL illegal_strobes: got iw/pw=%b%b expected 00",
                             bus.ir_write, bus.pc_write);
                else n_pass++;
            end
            if (i < 2) tick();
        end
    endtask

    task automatic test_reset_mid();
        bus.mem_ready = 1'b1;
        bus.opcode = OP_ADDI;
        tick();
        tick();
        #1;
        n_total++;
        if ({bus.state, bus.alu_src_b} !== 6'b1010_10)
            $display("FAIL mid_addi_ex: got st=%0d srcb=%b expected 10 10", bus.state, bus.alu_src_b);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if (all_outs !== 22'd0) $display("FAIL mid_reset_outs: got %h expected 0", all_outs);
        else n_pass++;
        tick();
        reset = 1'b0;
        #1;
        n_total++;
        if ({bus.state, bus.reg_write, bus.mem_read} !== 6'b0000_01)
            $display("FAIL mid_reset_after: got st=%0d rw=%b mr=%b expected 0 0 1",
                     bus.state, bus.reg_write, bus.mem_read);
        else n_pass++;
        tick();
        #1;
        n_total++;
        if ({bus.state, bus.reg_write} !== 5'b0001_0)
            $display("FAIL mid_reset_next: got st=%0d rw=%b expected 1 0", bus.state, bus.reg_write);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        bus.opcode = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_fetch_stall_jump();
        test_lw();
        test_beq();
        test_r_sw();
        test_addi();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the MIPS core. It replaces single-cycle decoding with a Moore FSM that steps one instruction through fetch, decode, execute, memory and writeback over 3–5 cycles. It drives the shared ALU, memory port, IR, PC and register-file enables. It sits between the instruction register/ALU-zero flag and the datapath muxes, and stalls on a memory-ready handshake.

## Interface
- No parameters; all encodings come from the package.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  6  instr[31:26] from IR; sampled in DECODE only
- zero  in  1  ALU zero flag, used in BRANCH
- mem_ready  in  1  memory completes the current access this cycle
- pc_write, pc_write_cond, pc_en  out  1  PC enables; pc_en = pc_write | (pc_write_cond & zero)
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut
- mem_read, mem_write, ir_write  out  1  memory and IR strobes
- reg_dst, mem_to_reg, reg_write  out  1  register-file write controls
- alu_src_a  out  1  ALU A select: 0 PC, 1 rs
- alu_src_b  out  2  ALU B select: 00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- illegal  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, for debug

## Operation
- Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- In DECODE, opcode is latched into op_q. Later states use op_q, never the live opcode.
- Outputs are Moore, decoded from state. Every output not listed for a state is 0.
- FETCH(0): mem_read=1, alu_src_b=01.
  - When mem_ready=1: ir_write=1, pc_write=1.
  - Exits to DECODE on mem_ready; otherwise holds.
- DECODE(1): alu_src_b=11 (branch target into ALUOut).
  - lw/sw go to MEM_ADDR; R goes to EXECUTE; beq to BRANCH; j to JUMP; addi to ADDI_EX.
  - Any other opcode: illegal=1 this cycle, next state FETCH.
- MEM_ADDR(2): alu_src_a=1, alu_src_b=10. Next state MEM_READ if op_q is lw, MEM_WRITE if sw.
- MEM_READ(3): mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB(4): mem_to_reg=1, reg_write=1. Next state FETCH.
- MEM_WRITE(5): mem_write=1, i_or_d=1. Holds until mem_ready, then goes to FETCH.
- EXECUTE(6): alu_src_a=1, alu_op=10. Next state R_WB.
- R_WB(7): reg_dst=1, reg_write=1. Next state FETCH.
- BRANCH(8): alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01. Next state FETCH.
- JUMP(9): pc_write=1, pc_source=10. Next state FETCH.
- ADDI_EX(10): alu_src_a=1, alu_src_b=10. Next state ADDI_WB.
- ADDI_WB(11): reg_write=1. Next state FETCH.
- Unreachable state codes 12–15 recover to FETCH on the next edge, with all outputs 0.

## Timing
- While reset=1, every output is forced to 0 combinationally, including illegal and pc_en.
- On a reset edge, state becomes FETCH and op_q becomes 0.
- The first fetch strobe appears in the first cycle with reset=0.
- Reset asserted mid-instruction aborts it at the next edge. No partial writeback occurs after that edge.
- Latency with mem_ready held at 1:
  - beq and j: 3 cycles
  - R, sw, addi: 4 cycles
  - lw: 5 cycles
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- In a stalled memory state, all strobes for that state stay stable; mem_write stays high until mem_ready.
- ir_write and pc_write fire exactly once per fetch, in the mem_ready cycle.
- zero is only acted on in BRANCH; it is ignored in all other states.

## Structure
- Package mips_ctrl_pkg holds:
  - the state enum (4-bit);
  - opcode constants;
  - alu_op, alu_src_b and pc_source encodings.
- The FSM register and next-state logic live in multicycle_control.
- Output decoding goes in sub-module ctrl_output_decode: purely combinational, inputs state and zero, outputs all datapath controls.

## Test plan
- Reset held 3 cycles, then released with mem_ready=1 → all outputs 0 during reset. First cycle after release: state=0, mem_read=1, pc_write=1, ir_write=1.
- lw (100011), mem_ready=0 for 2 cycles in MEM_READ → state sequence 0,1,2,3,3,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4.
- beq with zero=1, then beq with zero=0 → pc_en=1 in BRANCH for the first and 0 for the second. Each instruction takes 3 cycles.
- R-type followed by sw → R_WB has reg_dst=1. MEM_WRITE has mem_write=1 and i_or_d=1. No reg_write during the sw.
- Opcode 111111 → illegal=1 for exactly one cycle in DECODE, then FETCH. No write strobes asserted.
- reset asserted in ADDI_EX → state=0 at the next edge and reg_write never pulses.
